// File: rtl/gray_pkg.sv
// rtl/gray_pkg.sv - shared constants and binary-to-Gray helper for the Gray counter
package gray_pkg;

    localparam int GRAY_MAX_WIDTH = 16;

    // Operates at the maximum width. Callers zero-extend narrower values and
    // truncate the result; the zero upper bits leave the low bits correct.
    function automatic logic [GRAY_MAX_WIDTH-1:0] bin_to_gray(
        input logic [GRAY_MAX_WIDTH-1:0] b
    );
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/gray_encoder.sv
// rtl/gray_encoder.sv - combinational WIDTH-bit binary-to-Gray encoder
module gray_encoder #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray
);

    assign gray[WIDTH-1] = bin[WIDTH-1];

    for (genvar i = 0; i < WIDTH-1; i++) begin : g_bit
        assign gray[i] = bin[i+1] ^ bin[i];
    end

endmodule

// File: rtl/gray_code_counter.sv
// rtl/gray_code_counter.sv - registered up/down binary counter with registered Gray output and wrap pulse
module gray_code_counter
    import gray_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray,
    output logic             wrap
);

    logic [WIDTH:0]   inc_ext;
    logic [WIDTH:0]   dec_ext;
    logic [WIDTH-1:0] bin_nxt;
    logic [WIDTH-1:0] gray_nxt;
    logic             wrap_nxt;

    // One extra bit catches the carry (up) or borrow (down); it feeds wrap only.
    assign inc_ext = {1'b0, bin} + {{WIDTH{1'b0}}, 1'b1};
    assign dec_ext = {1'b0, bin} - {{WIDTH{1'b0}}, 1'b1};

    always_comb begin
        bin_nxt  = bin;
        wrap_nxt = 1'b0;
        if (load) begin
            bin_nxt = load_val;
        end else if (en) begin
            if (up) begin
                bin_nxt  = inc_ext[WIDTH-1:0];
                wrap_nxt = inc_ext[WIDTH];
            end else begin
                bin_nxt  = dec_ext[WIDTH-1:0];
                wrap_nxt = dec_ext[WIDTH];
            end
        end
    end

    // Encoding the next-state value keeps gray in lockstep with bin.
    gray_encoder #(
        .WIDTH (WIDTH)
    ) u_gray_encoder (
        .bin  (bin_nxt),
        .gray (gray_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin  <= '0;
            gray <= '0;
            wrap <= 1'b0;
        end else begin
            bin  <= bin_nxt;
            gray <= gray_nxt;
            wrap <= wrap_nxt;
        end
    end

endmodule

// File: tb/tb_gray_code_counter.sv
// tb/tb_gray_code_counter.sv - self-checking bench for gray_code_counter against a behavioural model
module tb_gray_code_counter;

    localparam int W   = 4;
    localparam int MOD = 1 << W;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en = 1'b0;
    logic         up = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] load_val = '0;
    logic [W-1:0] bin;
    logic [W-1:0] gray;
    logic         wrap;

    int   checks = 0;
    int   failures = 0;
    int   m_bin = 0;
    logic m_wrap = 1'b0;

    gray_code_counter #(
        .WIDTH (W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .up       (up),
        .load     (load),
        .load_val (load_val),
        .bin      (bin),
        .gray     (gray),
        .wrap     (wrap)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] ref_gray(input int b);
        return W'(b ^ (b >> 1));
    endfunction

    // Drive one cycle of inputs, advance past the edge and update the model.
    task automatic step(input logic l, input logic e, input logic u, input logic [W-1:0] lv);
        load     = l;
        en       = e;
        up       = u;
        load_val = lv;
        @(posedge clk);
        #1;
        if (l) begin
            m_bin  = int'(lv);
            m_wrap = 1'b0;
        end else if (e) begin
            if (u) begin
                m_wrap = (m_bin == MOD - 1);
                m_bin  = (m_bin + 1) % MOD;
            end else begin
                m_wrap = (m_bin == 0);
                m_bin  = (m_bin + MOD - 1) % MOD;
            end
        end else begin
            m_wrap = 1'b0;
        end
    endtask

    task automatic test_reset;
        step(1'b1, 1'b0, 1'b0, 4'b0101);
        step(1'b0, 1'b1, 1'b1, 4'b0000);
        checks++;
        if (bin !== 4'b0110) begin
            failures++;
            $display("FAIL reset_pre bin got=%b exp=0110", bin);
        end
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bin !== 4'b0000 || gray !== 4'b0000 || wrap !== 1'b0) begin
            failures++;
            $display("FAIL reset_async got bin=%b gray=%b wrap=%b exp 0000/0000/0", bin, gray, wrap);
        end
        m_bin  = 0;
        m_wrap = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (bin !== 4'b0000 || gray !== 4'b0000 || wrap !== 1'b0) begin
            failures++;
            $display("FAIL reset_hold got bin=%b gray=%b wrap=%b exp 0000/0000/0", bin, gray, wrap);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 1'b1, 1'b1, 4'b0000);
        checks++;
        if (bin !== 4'b0001 || gray !== 4'b0001 || wrap !== 1'b0) begin
            failures++;
            $display("FAIL reset_release got bin=%b gray=%b wrap=%b exp 0001/0001/0", bin, gray, wrap);
        end
    endtask

    task automatic test_up_sweep;
        logic [W-1:0] exp_seq [16] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110,
                                       4'b0111, 4'b0101, 4'b0100, 4'b1100,
                                       4'b1101, 4'b1111, 4'b1110, 4'b1010,
                                       4'b1011, 4'b1001, 4'b1000, 4'b0000};
        logic exp_wrap;
        step(1'b1, 1'b0, 1'b0, 4'b0000);
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b1, 1'b1, 4'b0000);
            exp_wrap = (i == 15);
            checks++;
            if (gray !== exp_seq[i] || wrap !== exp_wrap || bin !== W'(m_bin)) begin
                failures++;
                $display("FAIL up_sweep[%0d] got bin=%b gray=%b wrap=%b exp bin=%b gray=%b wrap=%b",
                         i, bin, gray, wrap, W'(m_bin), exp_seq[i], exp_wrap);
            end
        end
    endtask

    task automatic test_down_wrap;
        step(1'b1, 1'b0, 1'b0, 4'b0000);
        step(1'b0, 1'b1, 1'b0, 4'b0000);
        checks++;
        if (bin !== 4'b1111 || gray !== 4'b1000 || wrap !== 1'b1) begin
            failures++;
            $display("FAIL down_wrap got bin=%b gray=%b wrap=%b exp 1111/1000/1", bin, gray, wrap);
        end
        step(1'b0, 1'b1, 1'b0, 4'b0000);
        checks++;
        if (bin !== 4'b1110 || gray !== 4'b1001 || wrap !== 1'b0) begin
            failures++;
            $display("FAIL down_next got bin=%b gray=%b wrap=%b exp 1110/1001/0", bin, gray, wrap);
        end
    endtask

    task automatic test_load_priority;
        step(1'b1, 1'b1, 1'b1, 4'b1010);
        checks++;
        if (bin !== 4'b1010 || gray !== 4'b1111 || wrap !== 1'b0) begin
            failures++;
            $display("FAIL load_priority got bin=%b gray=%b wrap=%b exp 1010/1111/0", bin, gray, wrap);
        end
        step(1'b1, 1'b1, 1'b0, 4'b1010);
        checks++;
        if (bin !== 4'b1010 || gray !== 4'b1111 || wrap !== 1'b0) begin
            failures++;
            $display("FAIL load_same got bin=%b gray=%b wrap=%b exp 1010/1111/0", bin, gray, wrap);
        end
        // Load over what would otherwise be an up-wrap must suppress wrap.
        step(1'b1, 1'b0, 1'b0, 4'b1111);
        step(1'b1, 1'b1, 1'b1, 4'b0011);
        checks++;
        if (bin !== 4'b0011 || gray !== 4'b0010 || wrap !== 1'b0) begin
            failures++;
            $display("FAIL load_over_wrap got bin=%b gray=%b wrap=%b exp 0011/0010/0", bin, gray, wrap);
        end
    endtask

    task automatic test_hold;
        step(1'b1, 1'b0, 1'b0, 4'b1111);
        step(1'b0, 1'b1, 1'b1, 4'b0000);
        step(1'b1, 1'b0, 1'b0, 4'b0101);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 1'($urandom), 4'($urandom));
            checks++;
            if (bin !== 4'b0101 || gray !== 4'b0111 || wrap !== 1'b0) begin
                failures++;
                $display("FAIL hold[%0d] got bin=%b gray=%b wrap=%b exp 0101/0111/0", i, bin, gray, wrap);
            end
        end
    endtask

    task automatic test_random_walk;
        logic         l, e, u;
        logic [W-1:0] lv;
        logic [W-1:0] prev_gray;
        for (int i = 0; i < 1000; i++) begin
            l  = ($urandom_range(0, 15) == 0);
            e  = ($urandom_range(0, 3) != 0);
            u  = 1'($urandom);
            lv = 4'($urandom);
            prev_gray = ref_gray(m_bin);
            step(l, e, u, lv);
            checks++;
            if (bin !== W'(m_bin) || wrap !== m_wrap) begin
                failures++;
                $display("FAIL walk_model[%0d] got bin=%b wrap=%b exp bin=%b wrap=%b",
                         i, bin, wrap, W'(m_bin), m_wrap);
            end
            checks++;
            if (gray !== ref_gray(m_bin)) begin
                failures++;
                $display("FAIL walk_gray[%0d] got gray=%b exp=%b", i, gray, ref_gray(m_bin));
            end
            if (!l && e) begin
                checks++;
                if ($countones(prev_gray ^ gray) != 1) begin
                    failures++;
                    $display("FAIL walk_hamming[%0d] got prev=%b now=%b distance=%0d exp 1",
                             i, prev_gray, gray, $countones(prev_gray ^ gray));
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout got no finish exp finish before 200000");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        #2;
        checks++;
        if (bin !== 4'b0000 || gray !== 4'b0000 || wrap !== 1'b0) begin
            failures++;
            $display("FAIL reset_initial got bin=%b gray=%b wrap=%b exp 0000/0000/0", bin, gray, wrap);
        end
        @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_up_sweep();
        test_down_wrap();
        test_load_priority();
        test_hold();
        test_random_walk();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
